// File: rtl/alu_multibyte_seq.sv
// -----------------------------------------------------------------------------
// alu_multibyte_seq
//
// Runs NBYTES-wide AND / OR / ADD / SUB (and optionally unsigned SLT) on a
// shared 8-bit combinational ALU, one byte per clock, LSB first. Carry is
// chained between bytes, the wide result is assembled internally and the zero
// flag is aggregated across all bytes. result/carry/zero are published only
// when an operation completes, so they never show partial values.
//
// Optional feature macro: ALU_SEQ_SLT_EN
//   defined   : op=100 is a wide unsigned set-less-than (runs the SUB sequence)
//   undefined : op=100 behaves like any other undefined op code
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, sampled only while not busy
//   op        in   000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (optional)
//   opa/opb   in   wide operands, captured on an accepted start
//   busy      out  high while bytes are being processed
//   done      out  one-cycle completion pulse
//   result    out  wide result, held until the next completion
//   carry     out  final carry (SUB: 1 = no borrow)
//   zero      out  1 when the completed result is zero
//   alu_a/b   out  ALU data inputs
//   alu_cs    out  ALU op select (000 AND, 001 OR, 110 ADC)
//   alu_cin   out  ALU carry in
//   alu_s     in   ALU result
//   alu_cout  in   ALU carry out
// -----------------------------------------------------------------------------
module alu_multibyte_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_cs,
    output logic                  alu_cin,
    input  logic [7:0]            alu_s,
    input  logic                  alu_cout
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    localparam logic [2:0] CS_AND = 3'b000;
    localparam logic [2:0] CS_OR  = 3'b001;
    localparam logic [2:0] CS_ADC = 3'b110;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [2:0]        op_q;
    logic [W-1:0]      a_q, b_q;
    logic [W-1:0]      acc_q;
    logic              carry_int_q;
    logic              zero_acc_q;
    logic [W-1:0]      result_q;
    logic              carry_q;
    logic              zero_q;
    logic              done_q;

    // Byte views of the captured operands and the accumulator with the
    // current ALU byte merged into slot idx.
    logic [7:0]        a_byte [NBYTES];
    logic [7:0]        b_byte [NBYTES];
    logic [W-1:0]      acc_ins;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign a_byte[gi] = a_q[8*gi +: 8];
        assign b_byte[gi] = b_q[8*gi +: 8];
        assign acc_ins[8*gi +: 8] = (idx_q == IDX_W'(gi)) ? alu_s : acc_q[8*gi +: 8];
    end

    // Op decode from the captured op code
    logic is_and, is_or, is_add, is_slt, is_sub_like, is_arith;

    assign is_and = (op_q == OP_AND);
    assign is_or  = (op_q == OP_OR);
    assign is_add = (op_q == OP_ADD);
`ifdef ALU_SEQ_SLT_EN
    assign is_slt = (op_q == OP_SLT);
`else
    assign is_slt = 1'b0;
`endif
    // SLT is computed as a subtraction; only its final write-back differs.
    assign is_sub_like = (op_q == OP_SUB) || is_slt;
    assign is_arith    = is_add || is_sub_like;

    logic accept;
    logic last_byte;
    logic cout_eff;
    logic byte_zero;

    assign accept    = (state_q == S_IDLE) && start;
    assign last_byte = (state_q == S_RUN) && (idx_q == LAST_IDX);
    // ALU carry_out is meaningless for AND/OR, so it never enters the chain.
    assign cout_eff  = is_arith ? alu_cout : 1'b0;
    assign byte_zero = (alu_s == 8'h00);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_RUN;
            S_RUN:   if (last_byte) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and ALU drive, combinational from registered state
    always_comb begin
        busy    = 1'b0;
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_cs  = CS_AND;
        alu_cin = 1'b0;
        if (state_q == S_RUN) begin
            busy  = 1'b1;
            alu_a = a_byte[idx_q];
            // Undefined ops keep alu_b=0 with AND, forcing a zero result.
            if (is_sub_like) begin
                alu_b = ~b_byte[idx_q];
            end else if (is_and || is_or || is_add) begin
                alu_b = b_byte[idx_q];
            end
            if (is_or) begin
                alu_cs = CS_OR;
            end else if (is_arith) begin
                alu_cs = CS_ADC;
            end
            // Byte 0 seeds the chain: 0 for ADD, 1 for a + ~b + 1.
            if (is_arith) begin
                alu_cin = (idx_q == '0) ? is_sub_like : carry_int_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            op_q        <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_int_q <= 1'b0;
            zero_acc_q  <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q        <= op;
                a_q         <= opa;
                b_q         <= opb;
                acc_q       <= '0;
                idx_q       <= '0;
                zero_acc_q  <= 1'b1;
                carry_int_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                acc_q       <= acc_ins;
                zero_acc_q  <= zero_acc_q & byte_zero;
                carry_int_q <= cout_eff;
                idx_q       <= last_byte ? '0 : idx_q + IDX_W'(1);
                if (last_byte) begin
                    done_q   <= 1'b1;
                    result_q <= acc_ins;
                    carry_q  <= cout_eff;
                    zero_q   <= zero_acc_q & byte_zero;
`ifdef ALU_SEQ_SLT_EN
                    // a < b (unsigned) exactly when a - b borrows.
                    if (is_slt) begin
                        result_q <= {{(W-1){1'b0}}, ~cout_eff};
                        zero_q   <= cout_eff;
                    end
`endif
                end
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
module tb_alu_multibyte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        busy, done, carry, zero;
    logic [31:0] result;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic [2:0]  alu_cs;
    logic        alu_cin, alu_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multibyte_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs), .alu_cin(alu_cin),
        .alu_s(alu_s), .alu_cout(alu_cout)
    );

    // Reference 8-bit ALU (AND / OR / ADC)
    always_comb begin
        alu_s    = 8'h00;
        alu_cout = 1'b0;
        case (alu_cs)
            3'b000:  alu_s = alu_a & alu_b;
            3'b001:  alu_s = alu_a | alu_b;
            3'b110:  {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            default: alu_s = 8'h00;
        endcase
    end

    // Issue one operation and wait (bounded) for done. sync=0 drives start in
    // the current negedge slot, used for back-to-back issue in a done cycle.
    task automatic run_op(input bit sync, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int busy_cycles, output int done_at,
                          output logic [3:0] cin_seq, output logic [7:0] b0,
                          output logic [2:0] cs0);
        if (sync) @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cycles = 0; done_at = -1; cin_seq = 4'b0; b0 = 8'h00; cs0 = 3'b000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy) begin
                if (busy_cycles == 0) begin b0 = alu_b; cs0 = alu_cs; end
                if (busy_cycles < 4) cin_seq[busy_cycles] = alu_cin;
                busy_cycles++;
            end
            if (done) begin done_at = c; break; end
        end
        $display("op=%b a=%h b=%h -> result=%h carry=%b zero=%b busy_cycles=%0d done_at=%0d",
                 o, a, b, result, carry, zero, busy_cycles, done_at);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'b000; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {carry, zero}); end
        checks++; if ({alu_a, alu_b, alu_cs, alu_cin} !== 20'h0) begin failures++; $display("FAIL reset_alu_idle got=%h exp=0", {alu_a, alu_b, alu_cs, alu_cin}); end
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
    endtask

    task automatic test_add();
        int bc, da; logic [3:0] cs; logic [7:0] b0; logic [2:0] c0;
        run_op(1, 3'b010, 32'h00FFFFFF, 32'h00000001, bc, da, cs, b0, c0);
        checks++; if (da !== 5) begin failures++; $display("FAIL add1_done_latency got=%0d exp=5", da); end
        checks++; if (bc !== 4) begin failures++; $display("FAIL add1_busy_cycles got=%0d exp=4", bc); end
        checks++; if (result !== 32'h01000000) begin failures++; $display("FAIL add1_result got=%h exp=01000000", result); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL add1_flags got=%b exp=00", {carry, zero}); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL add1_done_pulse got=%b exp=0", done); end
        run_op(1, 3'b010, 32'hFFFFFFFF, 32'h00000001, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h00000000) begin failures++; $display("FAIL add2_result got=%h exp=00000000", result); end
        checks++; if ({carry, zero} !== 2'b11) begin failures++; $display("FAIL add2_flags got=%b exp=11", {carry, zero}); end
        checks++; if (cs !== 4'b1110) begin failures++; $display("FAIL add2_cin_seq got=%b exp=1110", cs); end
        checks++; if (c0 !== 3'b110) begin failures++; $display("FAIL add2_alu_cs got=%b exp=110", c0); end
    endtask

    task automatic test_sub();
        int bc, da; logic [3:0] cs; logic [7:0] b0; logic [2:0] c0;
        run_op(1, 3'b011, 32'h10000000, 32'h00000001, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h0FFFFFFF) begin failures++; $display("FAIL sub1_result got=%h exp=0FFFFFFF", result); end
        checks++; if ({carry, zero} !== 2'b10) begin failures++; $display("FAIL sub1_flags got=%b exp=10", {carry, zero}); end
        run_op(1, 3'b011, 32'h00000005, 32'h00000007, bc, da, cs, b0, c0);
        checks++; if (result !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub2_result got=%h exp=FFFFFFFE", result); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL sub2_flags got=%b exp=00", {carry, zero}); end
        checks++; if (b0 !== 8'hF8) begin failures++; $display("FAIL sub2_alu_b_inv got=%h exp=F8", b0); end
        checks++; if (cs[0] !== 1'b1) begin failures++; $display("FAIL sub2_cin0 got=%b exp=1", cs[0]); end
    endtask

    task automatic test_logic();
        int bc, da; logic [3:0] cs; logic [7:0] b0; logic [2:0] c0;
        run_op(1, 3'b000, 32'hF0F0A5A5, 32'h0FF0FF00, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h00F0A500) begin failures++; $display("FAIL and_result got=%h exp=00F0A500", result); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL and_flags got=%b exp=00", {carry, zero}); end
        run_op(1, 3'b001, 32'h12000034, 32'h00560000, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h12560034) begin failures++; $display("FAIL or_result got=%h exp=12560034", result); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL or_flags got=%b exp=00", {carry, zero}); end
        checks++; if (c0 !== 3'b001) begin failures++; $display("FAIL or_alu_cs got=%b exp=001", c0); end
    endtask

    task automatic test_undefined();
        int bc, da; logic [3:0] cs; logic [7:0] b0; logic [2:0] c0;
        run_op(1, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, da, cs, b0, c0);
        checks++; if (da !== 5) begin failures++; $display("FAIL undef_done_latency got=%0d exp=5", da); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL undef_result got=%h exp=00000000", result); end
        checks++; if ({carry, zero} !== 2'b01) begin failures++; $display("FAIL undef_flags got=%b exp=01", {carry, zero}); end
        checks++; if ({c0, b0} !== 11'h0) begin failures++; $display("FAIL undef_alu_drive got=%h exp=0", {c0, b0}); end
    endtask

    task automatic test_slt();
        int bc, da; logic [3:0] cs; logic [7:0] b0; logic [2:0] c0;
`ifdef ALU_SEQ_SLT_EN
        run_op(1, 3'b100, 32'h00000003, 32'h00000009, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h00000001) begin failures++; $display("FAIL slt1_result got=%h exp=00000001", result); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL slt1_flags got=%b exp=00", {carry, zero}); end
        run_op(1, 3'b100, 32'h80000000, 32'h7FFFFFFF, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h00000000) begin failures++; $display("FAIL slt2_result got=%h exp=00000000", result); end
        checks++; if ({carry, zero} !== 2'b11) begin failures++; $display("FAIL slt2_flags got=%b exp=11", {carry, zero}); end
`else
        run_op(1, 3'b100, 32'h00000003, 32'h00000009, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h00000000) begin failures++; $display("FAIL op100_result got=%h exp=00000000", result); end
        checks++; if ({carry, zero} !== 2'b01) begin failures++; $display("FAIL op100_flags got=%b exp=01", {carry, zero}); end
`endif
    endtask

    task automatic test_busy_ignore();
        int da, extra;
        da = -1; extra = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b010; opa = 32'h00000010; opb = 32'h00000020;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) begin start = 1'b1; op = 3'b000; opa = 32'hFFFFFFFF; opb = 32'h0; end
            if (c == 3) start = 1'b0;
            if (done) begin da = c; break; end
        end
        $display("busy_ignore: result=%h done_at=%0d", result, da);
        checks++; if (da !== 5) begin failures++; $display("FAIL ignore_done_latency got=%0d exp=5", da); end
        checks++; if (result !== 32'h00000030) begin failures++; $display("FAIL ignore_result got=%h exp=00000030", result); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_no_queue got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int bc, da; logic [3:0] cs; logic [7:0] b0; logic [2:0] c0;
        run_op(1, 3'b001, 32'h12000034, 32'h00560000, bc, da, cs, b0, c0);
        checks++; if (result !== 32'h12560034) begin failures++; $display("FAIL b2b_first_result got=%h exp=12560034", result); end
        run_op(0, 3'b000, 32'hF0F0A5A5, 32'h0FF0FF00, bc, da, cs, b0, c0);
        checks++; if (da !== 5) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=5", da); end
        checks++; if (bc !== 4) begin failures++; $display("FAIL b2b_second_busy got=%0d exp=4", bc); end
        checks++; if (result !== 32'h00F0A500) begin failures++; $display("FAIL b2b_second_result got=%h exp=00F0A500", result); end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b010; opa = 32'h01010101; opb = 32'h02020202;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("reset_abort: busy=%b result=%h carry=%b zero=%b", busy, result, carry, zero);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=00000000", result); end
        for (int c = 0; c < 8; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        checks++; if (seen_done !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_undefined();
        test_slt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
